// File: rtl/wave_pkg.sv
// Shared waveform types and default levels, used by the analyzer and the generator bench.
package wave_pkg;
  localparam int WAVE_W    = 8;
  localparam int WAVE_MID  = 128;
  localparam int WAVE_HYST = 16;

  typedef enum logic {IDLE, MEASURE} state_t;

  function automatic logic [WAVE_W-1:0] smin(input logic [WAVE_W-1:0] a, input logic [WAVE_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [WAVE_W-1:0] smax(input logic [WAVE_W-1:0] a, input logic [WAVE_W-1:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/waveform_analyzer_if.sv
// Sample stream in, per-period measurement out; master drives samples, slave is the analyzer.
interface waveform_analyzer_if
  import wave_pkg::*;
#(
  parameter int PW = 16
);
  logic [WAVE_W-1:0] sample_in;
  logic              sample_vld;
  logic [PW-1:0]     period_out;
  logic [WAVE_W-1:0] min_out;
  logic [WAVE_W-1:0] max_out;
  logic              res_vld;
  logic              flat;

  modport master (
    output sample_in, sample_vld,
    input  period_out, min_out, max_out, res_vld, flat
  );

  modport slave (
    input  sample_in, sample_vld,
    output period_out, min_out, max_out, res_vld, flat
  );
endinterface

// File: rtl/crossing_detector.sv
// Hysteretic rising-crossing detector: arms at or below MID-HYST, fires at or above MID+HYST.
module crossing_detector
  import wave_pkg::*;
#(
  parameter int MID  = WAVE_MID,
  parameter int HYST = WAVE_HYST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WAVE_W-1:0] sample_in,
  input  logic              sample_vld,
  output logic              rise
);
  localparam logic [WAVE_W-1:0] ARM_LVL  = WAVE_W'(MID - HYST);
  localparam logic [WAVE_W-1:0] FIRE_LVL = WAVE_W'(MID + HYST);

  logic armed_q;

  // Uses the armed value from before this sample, so one sample cannot arm and fire.
  assign rise = sample_vld & armed_q & (sample_in >= FIRE_LVL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q <= 1'b0;
    end else if (sample_vld) begin
      if (rise)
        armed_q <= 1'b0;
      else if (sample_in <= ARM_LVL)
        armed_q <= 1'b1;
    end
  end
endmodule

// File: rtl/waveform_analyzer.sv
// Measures period, min and max between successive rising crossings; result pulse 1 clk after
// the closing crossing. flat flags a period that saturates the counter.
module waveform_analyzer
  import wave_pkg::*;
#(
  parameter int PW   = 16,
  parameter int MID  = WAVE_MID,
  parameter int HYST = WAVE_HYST
) (
  input  logic                clk,
  input  logic                rst,
  waveform_analyzer_if.slave  wif
);
  localparam logic [PW-1:0] CNT_MAX = '1;

  state_t            state_q;
  logic [PW-1:0]     cnt_q;
  logic [WAVE_W-1:0] rmin_q, rmax_q;
  logic [PW-1:0]     period_q;
  logic [WAVE_W-1:0] min_q, max_q;
  logic              res_vld_q, flat_q;
  logic              rise;
  logic [WAVE_W-1:0] rmin_d, rmax_d;

  crossing_detector #(.MID(MID), .HYST(HYST)) u_xdet (
    .clk        (clk),
    .rst        (rst),
    .sample_in  (wif.sample_in),
    .sample_vld (wif.sample_vld),
    .rise       (rise)
  );

  assign rmin_d = smin(rmin_q, wif.sample_in);
  assign rmax_d = smax(rmax_q, wif.sample_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rmin_q    <= '0;
      rmax_q    <= '0;
      period_q  <= '0;
      min_q     <= '0;
      max_q     <= '0;
      res_vld_q <= 1'b0;
      flat_q    <= 1'b0;
    end else begin
      res_vld_q <= 1'b0;
      if (wif.sample_vld) begin
        case (state_q)
          IDLE: begin
            if (rise) begin
              state_q <= MEASURE;
              cnt_q   <= PW'(1);
              rmin_q  <= wif.sample_in;
              rmax_q  <= wif.sample_in;
            end
          end
          MEASURE: begin
            if (rise) begin
              // The crossing sample closes this period and opens the next one.
              period_q  <= cnt_q;
              min_q     <= rmin_q;
              max_q     <= rmax_q;
              res_vld_q <= 1'b1;
              flat_q    <= 1'b0;
              cnt_q     <= PW'(1);
              rmin_q    <= wif.sample_in;
              rmax_q    <= wif.sample_in;
            end else if (cnt_q == CNT_MAX) begin
              flat_q  <= 1'b1;
              state_q <= IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q  <= cnt_q + PW'(1);
              rmin_q <= rmin_d;
              rmax_q <= rmax_d;
            end
          end
        endcase
      end
    end
  end

  assign wif.period_out = period_q;
  assign wif.min_out    = min_q;
  assign wif.max_out    = max_q;
  assign wif.res_vld    = res_vld_q;
  assign wif.flat       = flat_q;
endmodule

// File: tb/tb_waveform_analyzer.sv
// Directed stimulus with a result scoreboard, on a PW=16 and a PW=8 analyzer.
module tb_waveform_analyzer;
  typedef struct {
    int period;
    int mn;
    int mx;
    int cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   ncyc;
  exp_t q16[$];
  exp_t q8[$];
  exp_t e;

  waveform_analyzer_if #(.PW(16)) if16 ();
  waveform_analyzer_if #(.PW(8))  if8 ();

  waveform_analyzer #(.PW(16), .MID(128), .HYST(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .wif (if16)
  );

  waveform_analyzer #(.PW(8), .MID(128), .HYST(16)) dut8 (
    .clk (clk),
    .rst (rst),
    .wif (if8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Monitor: every res_vld pulse must match the head of its DUT's queue.
  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (if16.res_vld === 1'b1) begin
      if (q16.size() == 0) begin
        chk("dut16_unexpected_res", 1, 0);
      end else begin
        e = q16.pop_front();
        chk("dut16_period", int'(if16.period_out), e.period);
        chk("dut16_min", int'(if16.min_out), e.mn);
        chk("dut16_max", int'(if16.max_out), e.mx);
        chk("dut16_res_cycle", ncyc, e.cyc);
        chk("dut16_flat_at_res", int'(if16.flat), 0);
      end
    end
    if (if8.res_vld === 1'b1) begin
      if (q8.size() == 0) begin
        chk("dut8_unexpected_res", 1, 0);
      end else begin
        e = q8.pop_front();
        chk("dut8_period", int'(if8.period_out), e.period);
        chk("dut8_min", int'(if8.min_out), e.mn);
        chk("dut8_max", int'(if8.max_out), e.mx);
        chk("dut8_res_cycle", ncyc, e.cyc);
        chk("dut8_flat_at_res", int'(if8.flat), 0);
      end
    end
  end

  task automatic step(input int which, input int s, input bit v);
    if (which == 16) begin
      if16.sample_in  = 8'(s);
      if16.sample_vld = v;
      if8.sample_vld  = 1'b0;
    end else begin
      if8.sample_in   = 8'(s);
      if8.sample_vld  = v;
      if16.sample_vld = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Result for the event sample just clocked in appears at the next monitor sample.
  task automatic push16(input int p, input int mn, input int mx);
    exp_t x;
    x.period = p; x.mn = mn; x.mx = mx; x.cyc = ncyc + 1;
    q16.push_back(x);
  endtask

  task automatic push8(input int p, input int mn, input int mx);
    exp_t x;
    x.period = p; x.mn = mn; x.mx = mx; x.cyc = ncyc + 1;
    q8.push_back(x);
  endtask

  task automatic do_reset();
    if16.sample_vld = 1'b0;
    if8.sample_vld  = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic square(input int which, input int reps, input int first_res);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < 50; i++) step(which, 0, 1'b1);
      for (int i = 0; i < 50; i++) begin
        step(which, 255, 1'b1);
        if (i == 0 && r >= first_res) begin
          if (which == 16) push16(100, 0, 255);
          else push8(100, 0, 255);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ncyc     = 0;
    rst      = 1'b0;
    if16.sample_in = 8'd0; if16.sample_vld = 1'b0;
    if8.sample_in  = 8'd0; if8.sample_vld  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_period16", int'(if16.period_out), 0);
    chk("rst_min16", int'(if16.min_out), 0);
    chk("rst_max16", int'(if16.max_out), 0);
    chk("rst_res_vld16", int'(if16.res_vld), 0);
    chk("rst_flat16", int'(if16.flat), 0);
    chk("rst_period8", int'(if8.period_out), 0);
    chk("rst_flat8", int'(if8.flat), 0);
    rst = 1'b1;

    // Sawtooth: first 144 only starts measuring.
    for (int r = 0; r < 3; r++)
      for (int v = 0; v < 256; v++) begin
        step(16, v, 1'b1);
        if (v == 144 && r > 0) push16(256, 0, 255);
      end
    chk("saw_flat16", int'(if16.flat), 0);

    // Square wave.
    do_reset();
    square(16, 5, 1);
    chk("square_flat16", int'(if16.flat), 0);

    // Sawtooth with gaps; invalid cycles carry 200.
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int v = 0; v < 256; v++) begin
        step(16, v, 1'b1);
        if (v == 144 && r > 0) push16(256, 0, 255);
        step(16, 200, 1'b0);
      end

    // Reset in the middle of a ramp after a result has been reported.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int v = 0; v < 256; v++) begin
        step(16, v, 1'b1);
        if (v == 144 && r > 0) push16(256, 0, 255);
      end
    for (int v = 0; v <= 60; v++) step(16, v, 1'b1);
    if16.sample_vld = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_period16", int'(if16.period_out), 0);
    chk("midrst_min16", int'(if16.min_out), 0);
    chk("midrst_max16", int'(if16.max_out), 0);
    chk("midrst_res_vld16", int'(if16.res_vld), 0);
    chk("midrst_flat16", int'(if16.flat), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int v = 61; v < 256; v++) step(16, v, 1'b1);
    for (int r = 0; r < 2; r++)
      for (int v = 0; v < 256; v++) begin
        step(16, v, 1'b1);
        if (v == 144) push16(256, 0, 255);
      end
    chk("midrst_q16_drained", q16.size(), 0);

    // Hysteresis with PW=8: one event, then timeout after 255 further samples.
    do_reset();
    step(8, 100, 1'b1);
    step(8, 150, 1'b1);
    for (int i = 1; i <= 254; i++) step(8, (i % 2) ? 140 : 150, 1'b1);
    chk("hyst_flat_before_timeout", int'(if8.flat), 0);
    step(8, 140, 1'b1);
    chk("hyst_flat_at_timeout", int'(if8.flat), 1);
    for (int i = 0; i < 20; i++) step(8, (i % 2) ? 140 : 150, 1'b1);
    chk("hyst_flat_holds", int'(if8.flat), 1);

    // Constant mid level never arms; sawtooth then saturates PW=8; square recovers.
    do_reset();
    for (int i = 0; i < 600; i++) step(8, 128, 1'b1);
    chk("const_flat8", int'(if8.flat), 0);
    for (int v = 0; v < 256; v++) step(8, v, 1'b1);
    for (int v = 0; v <= 142; v++) step(8, v, 1'b1);
    chk("saw8_flat_before_timeout", int'(if8.flat), 0);
    step(8, 143, 1'b1);
    chk("saw8_flat_at_timeout", int'(if8.flat), 1);
    for (int i = 0; i < 50; i++) step(8, 0, 1'b1);
    for (int i = 0; i < 50; i++) step(8, 255, 1'b1);
    chk("square8_flat_held_in_measure", int'(if8.flat), 1);
    square(8, 2, 0);
    chk("square8_flat_cleared", int'(if8.flat), 0);

    for (int i = 0; i < 4; i++) step(16, 0, 1'b0);
    chk("final_q16_empty", q16.size(), 0);
    chk("final_q8_empty", q8.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
